// File: rtl/keying_sched.sv
// Carrier-keying symbol scheduler: bit FIFO, per-symbol timing, phase accumulator and ROM addressing.
// Optional build macro KEY_PRBS_EN adds prbs_sel and an internal x^7+x^6+1 PRBS bit source.
module keying_sched #(
    parameter int SYM_CYCLES = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [7:0] step0,
    input  logic [7:0] step1,
    input  logic       bit_valid,
    input  logic       bit_data,
`ifdef KEY_PRBS_EN
    input  logic       prbs_sel,
`endif
    output logic       bit_ready,
    output logic [7:0] rom_addr,
    output logic       carrier_on,
    output logic       sym_strobe,
    output logic       idle,
    output logic [4:0] fifo_level
);
    localparam int         PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH5   = 5'(FIFO_DEPTH);
    localparam logic [15:0] LAST_CNT = 16'(SYM_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_ASK  = 2'b00,
        MODE_FSK  = 2'b01,
        MODE_BPSK = 2'b10,
        MODE_RSVD = 2'b11
    } key_mode_e;

    typedef enum logic {
        S_IDLE,
        S_SYM
    } state_e;

    state_e           state;
    key_mode_e        cur_mode;
    logic             cur_bit;
    logic [7:0]       cur_step0;
    logic [7:0]       cur_step1;
    logic [7:0]       phase;
    logic [15:0]      sym_cnt;

    logic             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [4:0]       count;

    logic             push;
    logic             pop;
    logic             src_prbs;
    logic             next_bit;
    logic             sym_end;
    logic             start;

    logic             nxt_active;
    logic             nxt_bit;
    key_mode_e        nxt_mode;
    logic [7:0]       phase_nxt;
    logic [7:0]       phase_inc;

`ifdef KEY_PRBS_EN
    logic [6:0] lfsr;

    assign src_prbs  = prbs_sel;
    assign bit_ready = !prbs_sel && (count != DEPTH5);
    assign next_bit  = prbs_sel ? lfsr[6] : fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 7'h7F;
        else if (start && prbs_sel)
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
`else
    assign src_prbs  = 1'b0;
    assign bit_ready = (count != DEPTH5);
    assign next_bit  = fifo_mem[rd_ptr];
`endif

    assign fifo_level = count;
    assign push       = bit_valid && bit_ready;
    assign sym_end    = (sym_cnt == LAST_CNT);
    // A PRBS symbol never waits on the FIFO, so PRBS symbols run back-to-back.
    assign start      = (src_prbs || (count != 5'd0)) && ((state == S_IDLE) || sym_end);
    assign pop        = start && !src_prbs;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        nxt_active = start || ((state == S_SYM) && !sym_end);
        nxt_bit    = start ? next_bit : cur_bit;
        nxt_mode   = start ? key_mode_e'(mode) : cur_mode;
        phase_inc  = ((cur_mode == MODE_FSK) && cur_bit) ? cur_step1 : cur_step0;
        phase_nxt  = (state == S_SYM) ? phase + phase_inc : phase;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the bit storage is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= bit_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sym_cnt    <= 16'd0;
            phase      <= 8'd0;
            cur_bit    <= 1'b0;
            cur_mode   <= MODE_ASK;
            cur_step0  <= 8'd0;
            cur_step1  <= 8'd0;
            rom_addr   <= 8'd0;
            carrier_on <= 1'b0;
            sym_strobe <= 1'b0;
            idle       <= 1'b1;
        end else begin
            state      <= nxt_active ? S_SYM : S_IDLE;
            idle       <= !nxt_active;
            sym_strobe <= start;
            phase      <= phase_nxt;
            if (start) begin
                sym_cnt   <= 16'd0;
                cur_bit   <= next_bit;
                cur_mode  <= key_mode_e'(mode);
                cur_step0 <= step0;
                cur_step1 <= step1;
            end else if (state == S_SYM) begin
                sym_cnt <= sym_cnt + 16'd1;
            end
            // BPSK keys a 180-degree shift by offsetting the shared sine-ROM address.
            rom_addr   <= phase_nxt + (((nxt_mode == MODE_BPSK) && nxt_bit) ? 8'd128 : 8'd0);
            if (!nxt_active)
                carrier_on <= 1'b0;
            else if ((nxt_mode == MODE_FSK) || (nxt_mode == MODE_BPSK))
                carrier_on <= 1'b1;
            else
                carrier_on <= nxt_bit;
        end
    end
endmodule
